// File: rtl/avr_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : avr_uart_pkg
// Brief    : Shared widths, line levels and receiver FSM encoding.
// Revision : 1.0 - initial release
// ============================================================================
package avr_uart_pkg;

    localparam int   UART_DATA_W     = 8;
    localparam logic UART_STOP_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_sync
// Brief    : Two-flop synchronizer for the serial line; resets to idle (1).
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/avr_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : avr_uart_rx
// Brief    : 8N1 LSB-first UART receiver with valid/ready output and sticky
//            overrun; even parity bit enabled by AVR_UART_RX_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module avr_uart_rx
    import avr_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rxd,
    output logic [UART_DATA_W-1:0] data,
    output logic                   valid,
    input  logic                   ready,
    output logic                   frame_err,
    output logic                   overrun,
    input  logic                   ovr_clr
);

    localparam int c_CW = $clog2(CLKS_PER_BIT);
    localparam int c_IW = $clog2(UART_DATA_W);
    localparam logic [c_CW-1:0] c_CNT_HALF = c_CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_CW-1:0] c_CNT_FULL = c_CW'(CLKS_PER_BIT - 1);
    localparam logic [c_IW-1:0] c_LAST_IDX = c_IW'(UART_DATA_W - 1);

    rx_state_t              r_state;
    rx_state_t              w_state_next;
    logic [c_CW-1:0]        r_cnt;
    logic [c_CW-1:0]        w_cnt_next;
    logic [c_IW-1:0]        r_idx;
    logic [UART_DATA_W-1:0] r_shift;
    logic [UART_DATA_W-1:0] r_data;
    logic                   r_valid;
    logic                   r_frame_err;
    logic                   r_overrun;

    logic w_rxs;
    logic w_tick;
    logic w_idx_clr;
    logic w_shift_en;
    logic w_stop_smp;
    logic w_par_bad;
    logic w_deliver;
    logic w_ferr;
    logic w_load_ok;

    uart_rx_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rxd),
        .q     (w_rxs)
    );

    assign w_tick = (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!w_rxs) w_state_next = ST_START;
            end
            ST_START: begin
                if (w_tick) w_state_next = w_rxs ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (w_tick && (r_idx == c_LAST_IDX)) begin
`ifdef AVR_UART_RX_PARITY_EN
                    w_state_next = ST_PARITY;
`else
                    w_state_next = ST_STOP;
`endif
                end
            end
`ifdef AVR_UART_RX_PARITY_EN
            ST_PARITY: begin
                if (w_tick) w_state_next = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (w_tick) begin
                    w_state_next = (w_rxs == UART_STOP_LEVEL) ? ST_IDLE : ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (w_rxs) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

`ifdef AVR_UART_RX_PARITY_EN
    logic w_par_smp;
`endif

    // Counter counts down to 0; each zero is a mid-bit sample point.
    always_comb begin
        w_cnt_next = w_tick ? '0 : r_cnt - 1'b1;
        w_idx_clr  = 1'b0;
        w_shift_en = 1'b0;
        w_stop_smp = 1'b0;
`ifdef AVR_UART_RX_PARITY_EN
        w_par_smp  = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (!w_rxs) w_cnt_next = c_CNT_HALF;
            end
            ST_START: begin
                if (w_tick && !w_rxs) begin
                    w_cnt_next = c_CNT_FULL;
                    w_idx_clr  = 1'b1;
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    w_cnt_next = c_CNT_FULL;
                    w_shift_en = 1'b1;
                end
            end
`ifdef AVR_UART_RX_PARITY_EN
            ST_PARITY: begin
                if (w_tick) begin
                    w_cnt_next = c_CNT_FULL;
                    w_par_smp  = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                w_stop_smp = w_tick;
            end
            default: begin
            end
        endcase
    end

`ifdef AVR_UART_RX_PARITY_EN
    logic r_par_bad;

    // Even parity: data bits plus parity bit must hold an even number of ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_par_bad <= 1'b0;
        end else if (w_par_smp) begin
            r_par_bad <= (^r_shift) ^ w_rxs;
        end
    end

    assign w_par_bad = r_par_bad;
`else
    assign w_par_bad = 1'b0;
`endif

    assign w_deliver = w_stop_smp && (w_rxs == UART_STOP_LEVEL) && !w_par_bad;
    assign w_ferr    = w_stop_smp && ((w_rxs != UART_STOP_LEVEL) || w_par_bad);
    assign w_load_ok = !r_valid || ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_idx       <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_next;
            r_frame_err <= w_ferr;

            if (w_idx_clr) begin
                r_idx <= '0;
            end else if (w_shift_en) begin
                r_idx <= r_idx + 1'b1;
            end

            if (w_shift_en) begin
                r_shift[r_idx] <= w_rxs;
            end

            if (w_deliver && w_load_ok) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (r_valid && ready) begin
                r_valid <= 1'b0;
            end

            // A new overrun takes priority over a clear in the same cycle.
            if (w_deliver && !w_load_ok) begin
                r_overrun <= 1'b1;
            end else if (ovr_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign data      = r_data;
    assign valid     = r_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire
